// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM stage of the pipeline.
//   - DATA_W_DEF / RD_W_DEF : default data/address and register-index widths
//   - mem_state_e           : memory-access FSM states
//   - mem_wb_t              : MEM/WB pipeline register record
package pipeline_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned RD_W_DEF   = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Fields are sized with the package defaults.
    typedef struct packed {
        logic                  regwrite;
        logic                  memtoreg;
        logic [RD_W_DEF-1:0]   rd;
        logic [DATA_W_DEF-1:0] readdata;
        logic [DATA_W_DEF-1:0] alu_result;
    } mem_wb_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts stalled cycles of an outstanding memory access.
//   i_clk      : clock
//   i_reset    : synchronous active-high reset (count -> 0)
//   i_en       : increment this cycle
//   i_clear    : return to 0 (has priority over i_en)
//   o_terminal : this is the TIMEOUT-th stalled cycle
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_clear,
    output logic o_terminal
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CW'(1);
        end
    end

    // The count already includes the first stalled cycle spent in IDLE,
    // so TIMEOUT-1 here means TIMEOUT cycles have stalled.
    assign o_terminal = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: consumes the EX/MEM register, resolves branches,
// performs loads/stores over a variable-latency req/ready handshake
// (stalling upstream while an access is outstanding) and drives MEM/WB.
//   clk, reset              : clock, synchronous active-high reset
//   EX_MEM_*                : registered EX/MEM control and data fields
//   mem_req/we/addr/wdata   : data-memory request
//   mem_ready/rdata         : data-memory completion and load data
//   stall                   : hold PC, IF/ID, ID/EX, EX/MEM
//   PCSrc, branch_target    : branch resolution
//   mem_error               : sticky access-timeout flag
//   MEM_WB_*                : MEM/WB pipeline register
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned RD_W    = RD_W_DEF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EX_MEM_RegWrite,
    input  logic              EX_MEM_MemRead,
    input  logic              EX_MEM_MemToReg,
    input  logic              EX_MEM_MemWrite,
    input  logic              EX_MEM_Branch,
    input  logic              EX_MEM_Zero,
    input  logic [RD_W-1:0]   EX_MEM_RD,
    input  logic [DATA_W-1:0] EX_MEM_Adder_out,
    input  logic [DATA_W-1:0] EX_MEM_ALU_Result,
    input  logic [DATA_W-1:0] EX_MEM_ReadData2,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              PCSrc,
    output logic [DATA_W-1:0] branch_target,
    output logic              mem_error,
    output logic              MEM_WB_RegWrite,
    output logic              MEM_WB_MemToReg,
    output logic [RD_W-1:0]   MEM_WB_RD,
    output logic [DATA_W-1:0] MEM_WB_ReadData,
    output logic [DATA_W-1:0] MEM_WB_ALU_Result
);

    mem_state_e        r_state;
    mem_state_e        w_state_d;
    logic              r_err;
    logic              r_we;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic [RD_W-1:0]   r_rd;
    logic [DATA_W-1:0] r_addr;      // doubles as the latched ALU result
    logic [DATA_W-1:0] r_wdata;
    mem_wb_t           r_mwb;
    mem_wb_t           w_mwb_d;

    logic w_acc;
    logic w_latch;
    logic w_set_err;
    logic w_cnt_en;
    logic w_cnt_clr;
    logic w_cnt_term;

    assign w_acc = EX_MEM_MemRead | EX_MEM_MemWrite;

    mem_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_en      (w_cnt_en),
        .i_clear   (w_cnt_clr),
        .o_terminal(w_cnt_term)
    );

    always_comb begin
        w_state_d = r_state;
        mem_req   = 1'b0;
        mem_we    = EX_MEM_MemWrite;
        mem_addr  = EX_MEM_ALU_Result;
        mem_wdata = EX_MEM_ReadData2;
        stall     = 1'b0;
        w_latch   = 1'b0;
        w_set_err = 1'b0;
        w_cnt_en  = 1'b0;
        w_cnt_clr = 1'b0;
        w_mwb_d   = r_mwb;

        unique case (r_state)
            IDLE: begin
                w_mwb_d.regwrite   = EX_MEM_RegWrite;
                w_mwb_d.memtoreg   = EX_MEM_MemToReg;
                w_mwb_d.rd         = EX_MEM_RD;
                w_mwb_d.alu_result = EX_MEM_ALU_Result;
                w_mwb_d.readdata   = '0;
                if (w_acc) begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        // MemWrite wins when both are set: no read data.
                        if (!EX_MEM_MemWrite) begin
                            w_mwb_d.readdata = mem_rdata;
                        end
                    end else begin
                        stall            = 1'b1;
                        w_latch          = 1'b1;
                        w_cnt_en         = 1'b1;
                        w_mwb_d          = r_mwb;
                        w_mwb_d.regwrite = 1'b0;
                        w_state_d        = WAIT;
                    end
                end
            end
            WAIT: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                stall     = ~mem_ready;
                if (mem_ready || w_cnt_term) begin
                    w_mwb_d.regwrite   = r_regwrite;
                    w_mwb_d.memtoreg   = r_memtoreg;
                    w_mwb_d.rd         = r_rd;
                    w_mwb_d.alu_result = r_addr;
                    w_mwb_d.readdata   = (mem_ready && !r_we) ? mem_rdata : '0;
                    w_cnt_clr          = 1'b1;
                    w_state_d          = IDLE;
                    if (!mem_ready) begin
                        w_set_err        = 1'b1;
                        w_mwb_d.regwrite = 1'b0;
                    end
                end else begin
                    w_cnt_en         = 1'b1;
                    w_mwb_d.regwrite = 1'b0;
                end
            end
            default: w_state_d = IDLE;
        endcase

        // Handshake and stall go quiet while reset is held.
        if (reset) begin
            mem_req = 1'b0;
            stall   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_err      <= 1'b0;
            r_we       <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_rd       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mwb      <= '0;
        end else begin
            r_state <= w_state_d;
            r_mwb   <= w_mwb_d;
            if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (w_latch) begin
                r_we       <= EX_MEM_MemWrite;
                r_regwrite <= EX_MEM_RegWrite;
                r_memtoreg <= EX_MEM_MemToReg;
                r_rd       <= EX_MEM_RD;
                r_addr     <= EX_MEM_ALU_Result;
                r_wdata    <= EX_MEM_ReadData2;
            end
        end
    end

    assign PCSrc             = EX_MEM_Branch & EX_MEM_Zero & (r_state == IDLE) & ~reset;
    assign branch_target     = EX_MEM_Adder_out;
    assign mem_error         = r_err;
    assign MEM_WB_RegWrite   = r_mwb.regwrite;
    assign MEM_WB_MemToReg   = r_mwb.memtoreg;
    assign MEM_WB_RD         = r_mwb.rd;
    assign MEM_WB_ReadData   = r_mwb.readdata;
    assign MEM_WB_ALU_Result = r_mwb.alu_result;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer side of the EX/MEM pipeline register bundle.
- Takes the registered EX/MEM control and data fields and resolves branches (PCSrc, target).
- Performs data-memory loads and stores over a variable-latency req/ready handshake, stalling the pipeline while an access is outstanding.
- Drives the MEM/WB pipeline register toward writeback.

Parameters:
- DATA_W, 64, data and address width.
- RD_W, 5, destination register index width.
- TIMEOUT, 16, max cycles waiting for mem_ready before abort (must be ≥2).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- EX_MEM_RegWrite  in  1  writeback enable.
- EX_MEM_MemRead  in  1  load.
- EX_MEM_MemToReg  in  1  writeback selects memory data.
- EX_MEM_MemWrite  in  1  store.
- EX_MEM_Branch  in  1  branch instruction.
- EX_MEM_Zero  in  1  ALU zero flag.
- EX_MEM_RD  in  RD_W  destination register.
- EX_MEM_Adder_out  in  DATA_W  branch target.
- EX_MEM_ALU_Result  in  DATA_W  memory address / ALU result.
- EX_MEM_ReadData2  in  DATA_W  store data.
- mem_req  out  1  access request.
- mem_we  out  1  1=store.
- mem_addr  out  DATA_W  access address.
- mem_wdata  out  DATA_W  store data.
- mem_ready  in  1  memory completes the access this cycle.
- mem_rdata  in  DATA_W  load data, valid when mem_ready.
- stall  out  1  upstream registers (PC, IF/ID, ID/EX, EX/MEM) must hold.
- PCSrc  out  1  take branch.
- branch_target  out  DATA_W  equals EX_MEM_Adder_out.
- mem_error  out  1  sticky timeout flag.
- MEM_WB_RegWrite  out  1  writeback enable.
- MEM_WB_MemToReg  out  1  writeback select.
- MEM_WB_RD  out  RD_W  destination register.
- MEM_WB_ReadData  out  DATA_W  load data.
- MEM_WB_ALU_Result  out  DATA_W  ALU result.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous, active-high.
- Reset: state=IDLE, mem_error=0, timeout counter=0, latched request regs=0, all MEM_WB_* outputs=0. stall, mem_req and PCSrc read 0 the cycle after reset is applied. Reset during WAIT abandons the access: mem_req low next cycle, no MEM/WB update.
- Access valid: acc = EX_MEM_MemRead | EX_MEM_MemWrite. If both are set, treat as store (MemWrite priority) and do not capture read data.
- IDLE, acc=0:
  - mem_req=0, stall=0.
  - MEM/WB captures EX_MEM fields next edge (1-cycle latency); MEM_WB_ReadData=0.
- IDLE, acc=1:
  - Combinationally drive mem_req=1, mem_we=MemWrite, mem_addr=ALU_Result, mem_wdata=ReadData2.
  - If mem_ready is high the same cycle: complete, stall=0, MEM/WB captures the instruction with ReadData=mem_rdata (stores: 0). Stay IDLE.
  - Otherwise: stall=1; latch we/addr/wdata/RD/RegWrite/MemToReg/ALU_Result; counter=1; go to WAIT.
- WAIT:
  - mem_req=1, driven from latched values only (EX_MEM inputs ignored).
  - stall = ~mem_ready.
  - MEM_WB_RegWrite is written 0 each stalled edge (bubble).
  - On mem_ready: MEM/WB captures the latched instruction plus mem_rdata; go to IDLE. The held EX/MEM content becomes the next instruction on the following cycle.
  - Else counter increments. When counter reaches TIMEOUT without ready: mem_error<=1 (sticky until reset), complete with ReadData=0 and RegWrite forced 0, go to IDLE.
- Branch:
  - PCSrc = EX_MEM_Branch & EX_MEM_Zero & (state==IDLE), combinational.
  - branch_target = EX_MEM_Adder_out.
  - Flushing younger stages is upstream's job.
- Back-to-back accesses: IDLE completion followed next cycle by a new access is legal. mem_req may stay high across the boundary with new address.
- mem_ready while mem_req=0 is ignored.

Decomposition:
- Shared package pipeline_pkg: state enum (IDLE, WAIT), DATA_W/RD_W defaults, MEM/WB bundle record type.
- One sub-module: mem_timeout_counter (enable, clear, terminal flag at TIMEOUT).

Test Plan:
- ALU op (RegWrite=1, RD=5, ALU_Result=0x2A, no access) -> next cycle MEM_WB_RD=5, MEM_WB_ALU_Result=0x2A, stall never 1.
- Load addr 0x100, mem_ready same cycle, rdata=0xDEAD -> mem_req=1 one cycle, stall=0, MEM_WB_ReadData=0xDEAD next cycle.
- Load addr 0x108, ready after 3 cycles, EX_MEM inputs changed during WAIT -> stall=1 for 3 cycles, mem_addr held 0x108, MEM_WB_RegWrite=0 during stall, final capture uses original RD.
- Store addr 0x40 data 0x55 with MemRead also set -> mem_we=1, mem_wdata=0x55, MEM_WB_ReadData=0.
- Load, mem_ready never asserted, TIMEOUT=16 -> stall high 16 cycles, then mem_error=1 sticky, MEM_WB_RegWrite=0. Reset pulse clears mem_error.
- Branch=1, Zero=1, Adder_out=0x80 in IDLE -> PCSrc=1, branch_target=0x80. Same inputs during WAIT -> PCSrc=0. Reset asserted mid-WAIT -> mem_req=0 next cycle.
